apb_bus_bridge: RTL and testbench
=================================

// Module: apb_bus_bridge
// PURPOSE
//  Parametrised bridge between the CPU_RV32I data bus and up to NUM_SLAVES APB-style peripherals
//  (RAM, GPIO, UART, timer). Replaces the fixed single-RAM data path of the MCU top.
//  Decodes the address, runs an APB SETUP/ACCESS transfer with wait states, stalls the CPU via
//  busReady, and flags decode/alignment/slave/timeout errors.
// PARAMETERS
//  NUM_SLAVES  4                    number of APB slaves (1..8)
//  SLAVE_BASE  {32'h1000_3000,32'h1000_2000,32'h1000_1000,32'h1000_0000}  packed base per slave, slave0 in LSBs
//  SLAVE_AW    12                   address bits decoded inside a slave (region size 2**SLAVE_AW bytes)
//  TIMEOUT     16                   max ACCESS cycles before abort (>=2)
// PORTS
//  clk         in   1               system clock
//  reset       in   1               synchronous, active-high
//  busReq      in   1               CPU request; held stable until busReady
//  busWe       in   1               1 = write, 0 = read
//  busSize     in   2               00 byte, 01 half, 10 word (11 = error)
//  busAddr     in   32              byte address
//  busWData    in   32              write data, lane-aligned by CPU
//  busRData    out  32              read data (full word), valid with busReady
//  busReady    out  1               one-cycle completion pulse
//  busErr      out  1               error qualifier, valid with busReady
//  PADDR       out  32              latched address
//  PWDATA      out  32              latched write data
//  PWRITE      out  1               latched direction
//  PSTRB       out  4               byte strobes (0 on reads)
//  PSEL        out  NUM_SLAVES      one-hot slave select
//  PENABLE     out  1               ACCESS phase
//  PRDATA      in   32*NUM_SLAVES   packed read data, slave0 in LSBs
//  PREADY      in   NUM_SLAVES      per-slave ready
//  PSLVERR     in   NUM_SLAVES      per-slave error
// BEHAVIOUR
//  - Reset: state IDLE; busRData, busReady, busErr, PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE all 0.
//  - Reset mid-transfer: abort; PSEL/PENABLE 0 next cycle; no busReady issued.
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE; IDLE -> ERR -> IDLE.
//  - IDLE: if busReq && !busReady, latch addr/wdata/we, compute strobes, decode.
//    hit && aligned && busSize!=11 -> SETUP; else -> ERR (no APB activity).
//  - Decode: slave i hits if busAddr[31:SLAVE_AW]==SLAVE_BASE[i][31:SLAVE_AW]; lowest index wins on overlap.
//  - Alignment: half needs addr[0]==0, word needs addr[1:0]==0.
//  - PSTRB (writes): byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF.
//  - SETUP: PSEL[i]=1, PENABLE=0, one cycle. ACCESS: PSEL[i]=1, PENABLE=1; wait counter starts at 0.
//  - ACCESS, PREADY[i]=1: capture PRDATA[i] (reads; writes load 0), busErr<=PSLVERR[i] -> RESP.
//  - ACCESS, counter==TIMEOUT-1 without PREADY: busErr<=1, busRData<=0 -> RESP (abort).
//  - PSEL/PENABLE drop in the cycle after PREADY/timeout sampled; PADDR/PWDATA/PSTRB hold until next latch.
//  - RESP and ERR: busReady=1 for exactly one cycle; ERR forces busErr=1, busRData=0. Then IDLE.
//  - Latency: zero-wait slave, req seen cycle 0 -> busReady cycle 3; +1 per wait cycle; ERR path cycle 1.
//  - busReq ignored outside IDLE and in the busReady cycle; next request accepted the cycle after.
//  - busReady, busErr, busRData registered; no combinational path from APB inputs to CPU outputs.
// STRUCTURE
//  - bus_pkg: typedef enum {IDLE,SETUP,ACCESS,RESP,ERR} bridge_state_t; typedef enum logic[1:0]
//    {SZ_BYTE,SZ_HALF,SZ_WORD} bus_size_t; localparam MAX_SLAVES=8.
//  - Sub-module apb_addr_decoder: combinational addr -> one-hot hit vector + hit flag (parametrised).
//  - Bridge: FSM, latches, strobe gen, wait counter ($clog2(TIMEOUT) bits), response regs.
// TESTING
//  - Word write 0x1000_0004 = 0xDEADBEEF, slave0 PREADY tied 1 -> PSEL=0001, PSTRB=F, busReady cycle 3, busErr=0.
//  - Byte write 0x1000_1003 data 0xAB000000, slave1 3 wait states -> PSTRB=1000, busReady cycle 6.
//  - Word read 0x1000_2008, slave2 PRDATA=0x1234_5678 -> busRData=0x1234_5678, busErr=0.
//  - Read 0x2000_0000 (no hit) and half read 0x1000_0001 -> no PSEL, busReady cycle 1, busErr=1, busRData=0.
//  - Slave3 PREADY held 0 -> busReady after TIMEOUT ACCESS cycles, busErr=1; PSLVERR=1 with PREADY -> busErr=1.
//  - Reset asserted during ACCESS -> PSEL=0, PENABLE=0 next cycle, busReady never pulses; next req works.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the CPU-to-APB bridge: FSM states, access sizes,
// and the byte-lane strobe / alignment rules used by the bridge request path.
package bus_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, ERR} bridge_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } bus_size_t;

  localparam int MAX_SLAVES = 8;

  function automatic logic [3:0] calc_strb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 4'b0001 << addr_lo;
      SZ_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
      SZ_WORD: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // Size 2'b11 is never aligned, which routes it to the error path.
  function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: compares the upper address bits against each
// slave base and returns a one-hot hit vector (lowest index wins) plus a hit flag.
module apb_addr_decoder
  import bus_pkg::*;
#(
  parameter int                      NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {32'h1000_3000, 32'h1000_2000,
                                                    32'h1000_1000, 32'h1000_0000},
  parameter int                      SLAVE_AW   = 12
) (
  input  logic [31:SLAVE_AW]     addr_i,
  output logic [NUM_SLAVES-1:0]  hit_vec_o,
  output logic                   hit_o
);

  // Scan from the top so the lowest matching index overwrites any higher one.
  always_comb begin
    hit_vec_o = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_i == SLAVE_BASE[32*i+SLAVE_AW +: 32-SLAVE_AW]) begin
        hit_vec_o = NUM_SLAVES'(1) << i;
      end
    end
  end

  assign hit_o = |hit_vec_o;

endmodule

// File: rtl/apb_bus_bridge.sv
// CPU data bus to APB bridge: decodes the request, runs SETUP/ACCESS with wait
// states and timeout, and returns a registered one-cycle busReady with error flag.
module apb_bus_bridge
  import bus_pkg::*;
#(
  parameter int                      NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {32'h1000_3000, 32'h1000_2000,
                                                    32'h1000_1000, 32'h1000_0000},
  parameter int                      SLAVE_AW   = 12,
  parameter int                      TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       busReq,
  input  logic                       busWe,
  input  logic [1:0]                 busSize,
  input  logic [31:0]                busAddr,
  input  logic [31:0]                busWData,
  output logic [31:0]                busRData,
  output logic                       busReady,
  output logic                       busErr,
  output logic [31:0]                PADDR,
  output logic [31:0]                PWDATA,
  output logic                       PWRITE,
  output logic [3:0]                 PSTRB,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY,
  input  logic [NUM_SLAVES-1:0]      PSLVERR
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  bridge_state_t         state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [31:0]           busrdata_q, paddr_q, pwdata_q;
  logic                  busready_q, buserr_q, pwrite_q, penable_q;
  logic [3:0]            pstrb_q;
  logic [NUM_SLAVES-1:0] psel_q;

  logic [NUM_SLAVES-1:0] hit_vec;
  logic                  hit;
  logic                  req_ok_d;
  logic [3:0]            pstrb_d;
  logic [31:0]           sel_rdata;
  logic                  sel_ready, sel_err;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_AW   (SLAVE_AW)
  ) u_dec (
    .addr_i    (busAddr[31:SLAVE_AW]),
    .hit_vec_o (hit_vec),
    .hit_o     (hit)
  );

  // Request qualification and the selected slave's response, muxed by the latched one-hot select.
  always_comb begin
    req_ok_d  = hit && addr_aligned(busSize, busAddr[1:0]);
    pstrb_d   = busWe ? calc_strb(busSize, busAddr[1:0]) : 4'h0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        sel_rdata = sel_rdata | PRDATA[32*i +: 32];
        sel_ready = sel_ready | PREADY[i];
        sel_err   = sel_err | PSLVERR[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busrdata_q <= '0;
      busready_q <= 1'b0;
      buserr_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      pstrb_q    <= 4'h0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (busReq && !busready_q) begin
            paddr_q  <= busAddr;
            pwdata_q <= busWData;
            pwrite_q <= busWe;
            pstrb_q  <= pstrb_d;
            if (req_ok_d) begin
              psel_q    <= hit_vec;
              penable_q <= 1'b0;
              state_q   <= SETUP;
            end else begin
              busready_q <= 1'b1;
              buserr_q   <= 1'b1;
              busrdata_q <= '0;
              state_q    <= ERR;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over a timeout landing in the same cycle.
          if (sel_ready) begin
            busrdata_q <= pwrite_q ? 32'h0 : sel_rdata;
            buserr_q   <= sel_err;
            busready_q <= 1'b1;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            state_q    <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            busrdata_q <= '0;
            buserr_q   <= 1'b1;
            busready_q <= 1'b1;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP, ERR: begin
          busready_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busRData = busrdata_q;
  assign busReady = busready_q;
  assign busErr   = buserr_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;
  assign PWRITE   = pwrite_q;
  assign PSTRB    = pstrb_q;
  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;

endmodule

// File: tb/tb_apb_bus_bridge.sv
// Bench for apb_bus_bridge: directed cases plus randomized transfers against
// configurable APB slave models and a transaction-level expectation model.
module tb_apb_bus_bridge;

  localparam int NS = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset, busReq, busWe;
  logic [1:0]        busSize;
  logic [31:0]       busAddr, busWData, busRData;
  logic              busReady, busErr;
  logic [31:0]       PADDR, PWDATA;
  logic              PWRITE, PENABLE;
  logic [3:0]        PSTRB;
  logic [NS-1:0]     PSEL, PREADY, PSLVERR;
  logic [32*NS-1:0]  PRDATA;

  int          wait_cfg [NS];
  logic [31:0] rdata_cfg[NS];
  logic        err_cfg  [NS];
  logic [31:0] base     [NS];
  int          acc_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  apb_bus_bridge #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE ({32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000}),
    .SLAVE_AW   (12),
    .TIMEOUT    (TO)
  ) dut (
    .clk(clk), .reset(reset), .busReq(busReq), .busWe(busWe), .busSize(busSize),
    .busAddr(busAddr), .busWData(busWData), .busRData(busRData), .busReady(busReady),
    .busErr(busErr), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Slave models: ready once the access phase has lasted wait_cfg cycles.
  always @(posedge clk) acc_cnt <= ((|PSEL) && PENABLE) ? acc_cnt + 1 : 0;

  always_comb begin
    PRDATA  = '0;
    PREADY  = '0;
    PSLVERR = '0;
    for (int i = 0; i < NS; i++) begin
      PRDATA[32*i +: 32] = rdata_cfg[i];
      PREADY[i]          = PSEL[i] && PENABLE && (acc_cnt >= wait_cfg[i]);
      PSLVERR[i]         = err_cfg[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int          idx, w, lat, exp_lat;
    logic        ok, exp_err, got_setup;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_psel, exp_strb, seen_psel, s_psel, s_strb;
    logic [31:0] s_addr, s_wdata;
    logic        s_en, s_write;
    idx = -1;
    for (int i = 0; i < NS; i++)
      if (idx < 0 && addr >= base[i] && addr < base[i] + 32'h1000) idx = i;
    ok = (idx >= 0) && (sz == 2'd0 || (sz == 2'd1 && addr % 2 == 0) ||
                        (sz == 2'd2 && addr % 4 == 0));
    exp_psel = '0; exp_strb = '0; exp_rdata = '0; exp_err = 1'b1; exp_lat = 1;
    if (ok) begin
      exp_psel = 4'(1 << idx);
      w = wait_cfg[idx];
      if (we) exp_strb = (sz == 2'd0) ? 4'(1 << (addr % 4)) :
                         (sz == 2'd1) ? 4'(3 << (addr % 4)) : 4'hF;
      if (w >= TO) begin
        exp_lat = 2 + TO;
      end else begin
        exp_lat   = 3 + w;
        exp_err   = err_cfg[idx];
        exp_rdata = we ? 32'h0 : rdata_cfg[idx];
      end
    end
    @(negedge clk);
    busReq = 1'b1; busWe = we; busSize = sz; busAddr = addr; busWData = wdata;
    lat = 0; got_setup = 1'b0; seen_psel = '0;
    s_psel = '0; s_strb = '0; s_addr = '0; s_wdata = '0; s_en = 1'b0; s_write = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen_psel = seen_psel | PSEL;
      if (PSEL != '0 && !got_setup) begin
        got_setup = 1'b1;
        s_psel = PSEL; s_en = PENABLE; s_strb = PSTRB;
        s_addr = PADDR; s_wdata = PWDATA; s_write = PWRITE;
      end
    end while (!busReady && lat < 200);
    chk("latency", lat, exp_lat);
    chk("busErr", 32'(busErr), 32'(exp_err));
    chk("busRData", busRData, exp_rdata);
    chk("psel_seen", 32'(seen_psel), 32'(exp_psel));
    chk("psel_drop", 32'({PSEL, PENABLE}), 32'h0);
    if (ok) begin
      chk("setup_penable", 32'(s_en), 32'h0);
      chk("setup_psel", 32'(s_psel), 32'(exp_psel));
      chk("pstrb", 32'(s_strb), 32'(exp_strb));
      chk("paddr", s_addr, addr);
      chk("pwdata", s_wdata, wdata);
      chk("pwrite", 32'(s_write), 32'(we));
    end
    busReq = 1'b0;
  endtask

  initial begin
    int   n;
    logic rdy_seen;
    int   s;
    logic [31:0] a;
    base[0] = 32'h1000_0000; base[1] = 32'h1000_1000;
    base[2] = 32'h1000_2000; base[3] = 32'h1000_3000;
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = 0; err_cfg[i] = 1'b0; rdata_cfg[i] = 32'hA5A5_0000 + 32'(i);
    end
    reset = 1'b1; busReq = 1'b0; busWe = 1'b0; busSize = 2'd0; busAddr = '0; busWData = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(busReady), 32'h0);
    chk("rst_err", 32'(busErr), 32'h0);
    chk("rst_rdata", busRData, 32'h0);
    chk("rst_psel", 32'({PSEL, PENABLE, PWRITE}), 32'h0);
    chk("rst_paddr", PADDR ^ PWDATA ^ 32'(PSTRB), 32'h0);
    reset = 1'b0;

    xfer(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF);
    wait_cfg[1] = 3;
    xfer(1'b1, 2'd0, 32'h1000_1003, 32'hAB00_0000);
    rdata_cfg[2] = 32'h1234_5678;
    xfer(1'b0, 2'd2, 32'h1000_2008, 32'h0);
    xfer(1'b0, 2'd2, 32'h2000_0000, 32'h0);
    xfer(1'b0, 2'd1, 32'h1000_0001, 32'h0);
    xfer(1'b1, 2'd3, 32'h1000_0000, 32'h1111_2222);
    xfer(1'b1, 2'd1, 32'h1000_2006, 32'hBEEF_0000);
    wait_cfg[3] = 1000;
    xfer(1'b0, 2'd2, 32'h1000_3000, 32'h0);
    wait_cfg[3] = TO - 1;
    xfer(1'b0, 2'd2, 32'h1000_3004, 32'h0);
    err_cfg[0] = 1'b1;
    xfer(1'b0, 2'd2, 32'h1000_0010, 32'h0);
    err_cfg[0] = 1'b0;

    // Reset during the access phase of a stalled transfer.
    wait_cfg[3] = 1000;
    @(negedge clk);
    busReq = 1'b1; busWe = 1'b0; busSize = 2'd2; busAddr = 32'h1000_3010;
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("rst_mid_access", 32'(PENABLE), 32'h1);
    reset = 1'b1; busReq = 1'b0;
    @(negedge clk);
    chk("rst_mid_psel", 32'({PSEL, PENABLE, busReady}), 32'h0);
    reset = 1'b0;
    rdy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      rdy_seen = rdy_seen | busReady;
    end
    chk("rst_mid_noready", 32'(rdy_seen), 32'h0);
    wait_cfg[3] = 2;
    xfer(1'b0, 2'd2, 32'h1000_3010, 32'h0);

    for (int k = 0; k < 40; k++) begin
      s = int'($urandom_range(0, 4));
      for (int i = 0; i < NS; i++) begin
        wait_cfg[i]  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
        err_cfg[i]   = ($urandom_range(0, 3) == 0);
        rdata_cfg[i] = $urandom;
      end
      if (s < NS) a = 32'h1000_0000 + 32'(s) * 32'h1000 + 32'($urandom_range(0, 4095));
      else        a = {4'h4, 28'($urandom)};
      xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
